// File: rtl/pc_sequencer.sv
// Program counter sequencer: registers the next fetch address (sequential, branch, jump, stall hold, halt) after a boot hold.
// Defining PC_SEQ_PERF_EN adds saturating fetch_count/stall_count performance counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0064,
  parameter int unsigned BOOT_CYCLES  = 2
`ifdef PC_SEQ_PERF_EN
  ,
  parameter int unsigned CNT_W        = 32
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        halt,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        pc_valid,
  output logic        flush,
  output logic        halted
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
`endif
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_STALL, ST_HALTED} state_t;

  localparam logic [31:0] BOOT_LAST = 32'(BOOT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] boot_cnt_q, boot_cnt_d;
  logic        flush_q, flush_d;
  logic [31:0] br_target, jmp_target;

  assign pc_plus4   = pc_q + 32'd4;
  assign br_target  = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jmp_target = {pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    boot_cnt_d = boot_cnt_q;
    flush_d    = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 32'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_STALL: begin
        // A redirect overrides a concurrent stall; jump outranks branch.
        if (halt) begin
          state_d = ST_HALTED;
        end else if (jump) begin
          pc_d    = jmp_target;
          flush_d = 1'b1;
          state_d = ST_RUN;
        end else if (branch_taken) begin
          pc_d    = br_target;
          flush_d = 1'b1;
          state_d = ST_RUN;
        end else if (stall) begin
          state_d = ST_STALL;
        end else begin
          pc_d    = pc_plus4;
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      boot_cnt_q <= 32'd0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      boot_cnt_q <= boot_cnt_d;
      flush_q    <= flush_d;
    end
  end

  assign pc_out   = pc_q;
  assign pc_valid = (state_q == ST_RUN) || (state_q == ST_STALL);
  assign flush    = flush_q;
  assign halted   = (state_q == ST_HALTED);

`ifdef PC_SEQ_PERF_EN
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             fetch_inc, stall_inc;

  // Leaving RUN/STALL into RUN always means pc_out was updated this edge.
  assign fetch_inc = pc_valid && (state_d == ST_RUN);
  assign stall_inc = (state_d == ST_STALL);

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_inc && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
